// File: rtl/sys_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sys_ctrl_pkg
// Shared definitions for the system controller pair (receive and transmit
// sides).
//   - 3-bit encodings for the transmit controller FSM states
//   - command opcodes used on the receive side
//   - helper that identifies the states in which a byte is offered to the UART
// -----------------------------------------------------------------------------
package sys_ctrl_pkg;

   localparam logic [2:0] ST_IDLE        = 3'd0;
   localparam logic [2:0] ST_RF_SEND     = 3'd1;
   localparam logic [2:0] ST_RF_WAIT     = 3'd2;
   localparam logic [2:0] ST_ALU_LO_SEND = 3'd3;
   localparam logic [2:0] ST_ALU_LO_WAIT = 3'd4;
   localparam logic [2:0] ST_ALU_HI_SEND = 3'd5;
   localparam logic [2:0] ST_ALU_HI_WAIT = 3'd6;

   typedef enum logic [2:0] {
      IDLE        = ST_IDLE,
      RF_SEND     = ST_RF_SEND,
      RF_WAIT     = ST_RF_WAIT,
      ALU_LO_SEND = ST_ALU_LO_SEND,
      ALU_LO_WAIT = ST_ALU_LO_WAIT,
      ALU_HI_SEND = ST_ALU_HI_SEND,
      ALU_HI_WAIT = ST_ALU_HI_WAIT
   } tx_state_e;

   // Frame command opcodes, shared with the receive controller
   localparam logic [7:0] CMD_RF_WR       = 8'hAA;
   localparam logic [7:0] CMD_RF_RD       = 8'hBB;
   localparam logic [7:0] CMD_ALU_OP      = 8'hCC;
   localparam logic [7:0] CMD_ALU_NO_OP   = 8'hDD;

   // True in the states where a byte is presented on the TX interface
   function automatic logic is_send_state(input tx_state_e s);
      return (s == RF_SEND) || (s == ALU_LO_SEND) || (s == ALU_HI_SEND);
   endfunction

endpackage

// File: rtl/tx_result_slot.sv
// -----------------------------------------------------------------------------
// tx_result_slot
// One-entry holding slot for a result waiting to be transmitted.
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   capture      single-cycle strobe, data_in valid
//   data_in      result to store
//   release_slot the transmitter is finished with the stored result
//   full         slot holds a result
//   data_out     stored result
//   overrun      combinational: a strobe hit a full slot this cycle (dropped)
// -----------------------------------------------------------------------------
module tx_result_slot #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             capture,
   input  logic [WIDTH-1:0] data_in,
   input  logic             release_slot,
   output logic             full,
   output logic [WIDTH-1:0] data_out,
   output logic             overrun
);

   // A release in the same cycle as a strobe frees room for the new
   // result, so the strobe is captured instead of being dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full     <= 1'b0;
         data_out <= '0;
      end else if (capture && (!full || release_slot)) begin
         full     <= 1'b1;
         data_out <= data_in;
      end else if (release_slot) begin
         full     <= 1'b0;
      end
   end

   // Dropped result: strobe while the slot is still occupied
   assign overrun = capture && full && !release_slot;

endmodule

// File: rtl/sys_ctrl_tx.sv
// -----------------------------------------------------------------------------
// sys_ctrl_tx
// Transmit-side system controller. Buffers one register-file read result and
// one ALU result, then serialises them as bytes into the UART transmitter
// (RF byte first; ALU low byte then high byte).
// Ports:
//   CLK            system clock, rising edge
//   RST            asynchronous active-low reset
//   RF_RdData      register-file read data
//   RF_RdData_VLD  single-cycle strobe for RF_RdData
//   ALU_OUT        ALU result (two bytes)
//   ALU_OUT_VLD    single-cycle strobe for ALU_OUT
//   TX_BUSY        UART transmitter busy
//   TX_P_DATA      byte offered to the UART (registered)
//   TX_D_VLD       TX_P_DATA valid, held until TX_BUSY is seen (registered)
//   CTRL_BUSY      work pending or transfer in progress (registered)
//   OVERRUN        one-cycle pulse when a result is dropped (registered)
// -----------------------------------------------------------------------------
module sys_ctrl_tx
   import sys_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [DATA_WIDTH-1:0]   RF_RdData,
   input  logic                    RF_RdData_VLD,
   input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
   input  logic                    ALU_OUT_VLD,
   input  logic                    TX_BUSY,
   output logic [DATA_WIDTH-1:0]   TX_P_DATA,
   output logic                    TX_D_VLD,
   output logic                    CTRL_BUSY,
   output logic                    OVERRUN
);

   tx_state_e               state;
   tx_state_e               next_state;

   logic                    rf_full;
   logic [DATA_WIDTH-1:0]   rf_data;
   logic                    rf_release;
   logic                    rf_overrun;

   logic                    alu_full;
   logic [2*DATA_WIDTH-1:0] alu_data;
   logic                    alu_release;
   logic                    alu_overrun;

   logic                    tx_vld_next;
   logic [DATA_WIDTH-1:0]   tx_data_next;

   tx_result_slot #(.WIDTH(DATA_WIDTH)) u_rf_slot (
      .clk          (CLK),
      .rst_n        (RST),
      .capture      (RF_RdData_VLD),
      .data_in      (RF_RdData),
      .release_slot (rf_release),
      .full         (rf_full),
      .data_out     (rf_data),
      .overrun      (rf_overrun)
   );

   tx_result_slot #(.WIDTH(2*DATA_WIDTH)) u_alu_slot (
      .clk          (CLK),
      .rst_n        (RST),
      .capture      (ALU_OUT_VLD),
      .data_in      (ALU_OUT),
      .release_slot (alu_release),
      .full         (alu_full),
      .data_out     (alu_data),
      .overrun      (alu_overrun)
   );

   // State register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic and slot releases. The ALU slot is only released once
   // its high byte has been taken, so an ALU result can never be split by an
   // RF byte. Unknown encodings fall back to IDLE.
   always_comb begin
      next_state  = state;
      rf_release  = 1'b0;
      alu_release = 1'b0;
      case (state)
         IDLE: begin
            if (!TX_BUSY && rf_full) begin
               next_state = RF_SEND;
            end else if (!TX_BUSY && alu_full) begin
               next_state = ALU_LO_SEND;
            end
         end
         RF_SEND: begin
            if (TX_BUSY) begin
               rf_release = 1'b1;
               next_state = RF_WAIT;
            end
         end
         RF_WAIT: begin
            if (!TX_BUSY) next_state = IDLE;
         end
         ALU_LO_SEND: begin
            if (TX_BUSY) next_state = ALU_LO_WAIT;
         end
         ALU_LO_WAIT: begin
            if (!TX_BUSY) next_state = ALU_HI_SEND;
         end
         ALU_HI_SEND: begin
            if (TX_BUSY) begin
               alu_release = 1'b1;
               next_state  = ALU_HI_WAIT;
            end
         end
         ALU_HI_WAIT: begin
            if (!TX_BUSY) next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // The TX outputs are decoded from the next state so that, although
   // registered, they change on the same edge as the state does.
   always_comb begin
      tx_vld_next  = is_send_state(next_state);
      tx_data_next = '0;
      case (next_state)
         RF_SEND:     tx_data_next = rf_data;
         ALU_LO_SEND: tx_data_next = alu_data[DATA_WIDTH-1:0];
         ALU_HI_SEND: tx_data_next = alu_data[2*DATA_WIDTH-1:DATA_WIDTH];
         default:     tx_data_next = '0;
      endcase
   end

   // Registered outputs
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         TX_P_DATA <= '0;
         TX_D_VLD  <= 1'b0;
         CTRL_BUSY <= 1'b0;
         OVERRUN   <= 1'b0;
      end else begin
         TX_P_DATA <= tx_data_next;
         TX_D_VLD  <= tx_vld_next;
         CTRL_BUSY <= (state != IDLE) || rf_full || alu_full;
         OVERRUN   <= rf_overrun || alu_overrun;
      end
   end

endmodule

// File: tb/tb_sys_ctrl_tx.sv
// -----------------------------------------------------------------------------
// tb_sys_ctrl_tx
// Scoreboard bench for sys_ctrl_tx. A UART model answers every accepted byte
// with a 10-cycle busy window; a monitor pops the expected byte queue at each
// acceptance.
// -----------------------------------------------------------------------------
module tb_sys_ctrl_tx;

   logic        CLK = 1'b0;
   logic        RST;
   logic [7:0]  RF_RdData;
   logic        RF_RdData_VLD;
   logic [15:0] ALU_OUT;
   logic        ALU_OUT_VLD;
   logic        TX_BUSY;
   logic [7:0]  TX_P_DATA;
   logic        TX_D_VLD;
   logic        CTRL_BUSY;
   logic        OVERRUN;

   int          compared   = 0;
   int          mismatched = 0;
   int          busy_cnt   = 0;
   int          ovr_count  = 0;
   logic        force_busy = 1'b0;
   logic [7:0]  exp_q[$];

   sys_ctrl_tx #(.DATA_WIDTH(8)) dut (
      .CLK           (CLK),
      .RST           (RST),
      .RF_RdData     (RF_RdData),
      .RF_RdData_VLD (RF_RdData_VLD),
      .ALU_OUT       (ALU_OUT),
      .ALU_OUT_VLD   (ALU_OUT_VLD),
      .TX_BUSY       (TX_BUSY),
      .TX_P_DATA     (TX_P_DATA),
      .TX_D_VLD      (TX_D_VLD),
      .CTRL_BUSY     (CTRL_BUSY),
      .OVERRUN       (OVERRUN)
   );

   // 100 MHz clock
   always #5 CLK = ~CLK;

   // UART model: a byte offered while idle is taken at the clock edge and
   // the line stays busy for the next 10 cycles
   assign TX_BUSY = force_busy || (busy_cnt > 0);

   always @(posedge CLK) begin
      if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
      else if (TX_D_VLD && !TX_BUSY) busy_cnt <= 10;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Monitor: compare every accepted byte against the scoreboard, make sure
   // the valid drops once each frame is underway, and count overrun pulses
   always @(negedge CLK) begin
      if (RST) begin
         if (TX_D_VLD && !TX_BUSY) begin
            if (exp_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("[TB] FAIL tx_byte: got 0x%02h, expected no byte", TX_P_DATA);
            end else begin
               checkOutput("tx_byte", {24'h0, TX_P_DATA}, {24'h0, exp_q.pop_front()});
            end
         end
         if (busy_cnt == 9) checkOutput("vld_low_in_frame", {31'h0, TX_D_VLD}, 32'h0);
         if (OVERRUN) ovr_count++;
      end
   end

   // One strobe cycle on either or both result inputs; returns #1 into the
   // cycle after the capture edge
   task automatic applyStimulus(input logic rf_v, input logic [7:0] rf_d,
                                input logic alu_v, input logic [15:0] alu_d);
      @(posedge CLK); #1;
      RF_RdData_VLD = rf_v;
      RF_RdData     = rf_d;
      ALU_OUT_VLD   = alu_v;
      ALU_OUT       = alu_d;
      @(posedge CLK); #1;
      RF_RdData_VLD = 1'b0;
      ALU_OUT_VLD   = 1'b0;
   endtask

   task automatic waitBusy(input logic level);
      int n;
      n = 0;
      while (TX_BUSY !== level && n < 100) begin
         @(posedge CLK); #1;
         n++;
      end
      if (TX_BUSY !== level) checkOutput("wait_tx_busy", {31'h0, TX_BUSY}, {31'h0, level});
   endtask

   task automatic waitDone();
      int n;
      n = 0;
      while (!(exp_q.size() == 0 && !TX_BUSY && !CTRL_BUSY && !TX_D_VLD) && n < 300) begin
         @(posedge CLK); #1;
         n++;
      end
      if (n >= 300) checkOutput("drain_timeout_pending", exp_q.size(), 32'h0);
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not complete, expected $finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic ok;
      RST           = 1'b0;
      RF_RdData     = 8'h00;
      RF_RdData_VLD = 1'b0;
      ALU_OUT       = 16'h0000;
      ALU_OUT_VLD   = 1'b0;

      // Reset state
      repeat (3) @(posedge CLK);
      #1;
      checkOutput("rst_tx_vld",    {31'h0, TX_D_VLD},  32'h0);
      checkOutput("rst_tx_data",   {24'h0, TX_P_DATA}, 32'h0);
      checkOutput("rst_ctrl_busy", {31'h0, CTRL_BUSY}, 32'h0);
      checkOutput("rst_overrun",   {31'h0, OVERRUN},   32'h0);
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1;

      // Single RF byte: latency of two cycles, busy status trails TX_BUSY
      exp_q.push_back(8'h5A);
      applyStimulus(1'b1, 8'h5A, 1'b0, 16'h0);
      checkOutput("rf_lat_n1_vld", {31'h0, TX_D_VLD}, 32'h0);
      @(posedge CLK); #1;
      checkOutput("rf_lat_n2_vld",  {31'h0, TX_D_VLD}, 32'h1);
      checkOutput("rf_lat_n2_data", {24'h0, TX_P_DATA}, 32'h5A);
      waitBusy(1'b1);
      waitBusy(1'b0);
      checkOutput("ctrl_busy_at_tx_fall", {31'h0, CTRL_BUSY}, 32'h1);
      repeat (2) @(posedge CLK);
      #1;
      checkOutput("ctrl_busy_cleared", {31'h0, CTRL_BUSY}, 32'h0);
      waitDone();

      // ALU result: low byte then high byte
      exp_q.push_back(8'h34);
      exp_q.push_back(8'h12);
      applyStimulus(1'b0, 8'h0, 1'b1, 16'h1234);
      waitDone();

      // Simultaneous results: RF first, then ALU low/high, nothing dropped
      exp_q.push_back(8'hA1);
      exp_q.push_back(8'hEF);
      exp_q.push_back(8'hBE);
      applyStimulus(1'b1, 8'hA1, 1'b1, 16'hBEEF);
      waitDone();
      checkOutput("no_overrun_simul", ovr_count, 32'h0);

      // Back-to-back RF results; the third hits a full slot and is dropped
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h02);
      applyStimulus(1'b1, 8'h01, 1'b0, 16'h0);
      waitBusy(1'b1);
      applyStimulus(1'b1, 8'h02, 1'b0, 16'h0);
      applyStimulus(1'b1, 8'h03, 1'b0, 16'h0);
      checkOutput("overrun_pulse", {31'h0, OVERRUN}, 32'h1);
      @(posedge CLK); #1;
      checkOutput("overrun_single", {31'h0, OVERRUN}, 32'h0);
      waitDone();
      checkOutput("overrun_count", ovr_count, 32'h1);

      // Transmitter busy before the result arrives: no offer until it frees
      force_busy = 1'b1;
      repeat (20) @(posedge CLK);
      #1;
      exp_q.push_back(8'h77);
      applyStimulus(1'b1, 8'h77, 1'b0, 16'h0);
      ok = 1'b1;
      repeat (20) begin
         @(posedge CLK); #1;
         if (TX_D_VLD) ok = 1'b0;
      end
      checkOutput("no_vld_while_busy", {31'h0, ok}, 32'h1);
      force_busy = 1'b0;
      waitDone();

      // Reset between the two ALU bytes: abort, high byte never sent
      exp_q.push_back(8'h34);
      applyStimulus(1'b0, 8'h0, 1'b1, 16'h1234);
      waitBusy(1'b1);
      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b0;
      #1;
      checkOutput("abort_tx_vld",    {31'h0, TX_D_VLD},  32'h0);
      checkOutput("abort_tx_data",   {24'h0, TX_P_DATA}, 32'h0);
      checkOutput("abort_ctrl_busy", {31'h0, CTRL_BUSY}, 32'h0);
      checkOutput("abort_overrun",   {31'h0, OVERRUN},   32'h0);
      @(posedge CLK); #1;
      RST = 1'b1;
      waitBusy(1'b0);
      repeat (15) @(posedge CLK);
      #1;
      checkOutput("no_resend_vld",  {31'h0, TX_D_VLD},  32'h0);
      checkOutput("no_resend_busy", {31'h0, CTRL_BUSY}, 32'h0);
      exp_q.push_back(8'h99);
      applyStimulus(1'b1, 8'h99, 1'b0, 16'h0);
      waitDone();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/sys_ctrl_tx.md
Name: sys_ctrl_tx

Overview:
Transmit-side system controller. It takes register-file read results (1 byte) and ALU results (2 bytes) produced by the receive-side controller's commands. It serialises them as bytes into the UART transmitter using a valid/busy handshake. It holds one pending slot per source, so back-to-back or simultaneous results are not lost, and it reports busy and overrun status.

Parameters:
DATA_WIDTH, 8, width of one UART byte and of RF read data; ALU result is 2*DATA_WIDTH.

Ports:
CLK  in  1  system clock; all logic on rising edge.
RST  in  1  asynchronous active-low reset.
RF_RdData  in  DATA_WIDTH  register-file read data.
RF_RdData_VLD  in  1  single-cycle strobe; RF_RdData valid this cycle.
ALU_OUT  in  2*DATA_WIDTH  ALU result.
ALU_OUT_VLD  in  1  single-cycle strobe; ALU_OUT valid this cycle.
TX_BUSY  in  1  UART TX busy; high while a frame is in flight.
TX_P_DATA  out  DATA_WIDTH  byte to transmit.
TX_D_VLD  out  1  TX_P_DATA valid; held until accepted.
CTRL_BUSY  out  1  high when any slot is pending or the FSM is not IDLE.
OVERRUN  out  1  one-cycle pulse when a result is dropped.

Behaviour:
- Reset (RST low, async): FSM to IDLE, both slots empty, TX_P_DATA=0, TX_D_VLD=0, CTRL_BUSY=0, OVERRUN=0. All outputs are registered.
- Slots: RF slot (DATA_WIDTH) and ALU slot (2*DATA_WIDTH), each with a full flag.
  - On a VLD strobe with the slot empty: capture data and set full at that clock edge.
  - On a VLD strobe with the slot full: data dropped, slot unchanged, OVERRUN=1 next cycle.
  - A strobe arriving in the same cycle the slot is released by the FSM is captured, with no overrun.
- TX handshake:
  - A byte is accepted in the cycle where TX_D_VLD=1 and TX_BUSY=0; TX_BUSY is expected high on the following cycle.
  - TX_D_VLD and TX_P_DATA remain stable until TX_BUSY is seen high.
- FSM states: IDLE, RF_SEND, RF_WAIT, ALU_LO_SEND, ALU_LO_WAIT, ALU_HI_SEND, ALU_HI_WAIT.
- IDLE:
  - If TX_BUSY=0 and RF slot full: go to RF_SEND.
  - Else if TX_BUSY=0 and ALU slot full: go to ALU_LO_SEND.
  - Else stay. RF has fixed priority over ALU.
- RF_SEND: drive TX_D_VLD=1, TX_P_DATA=RF slot. On TX_BUSY=1, clear TX_D_VLD, release RF slot, go to RF_WAIT.
- RF_WAIT: on TX_BUSY=0, go to IDLE.
- ALU_LO_SEND: drive ALU slot[DATA_WIDTH-1:0]. On TX_BUSY=1, go to ALU_LO_WAIT.
- ALU_LO_WAIT: on TX_BUSY=0, go to ALU_HI_SEND.
- ALU_HI_SEND: drive ALU slot[2*DATA_WIDTH-1:DATA_WIDTH]. On TX_BUSY=1, release ALU slot, go to ALU_HI_WAIT.
- ALU_HI_WAIT: on TX_BUSY=0, go to IDLE.
- The ALU slot is held for the whole 2-byte transfer. An RF result arriving mid-ALU-transfer waits and is sent after the high byte. An ALU result never interleaves between its own two bytes.
- Latency: a strobe at cycle N, in IDLE, with TX_BUSY=0 and the slot empty, gives TX_D_VLD=1 at cycle N+2 (capture edge at end of N, state transition at end of N+1).
- Simultaneous RF and ALU strobes: both captured, order RF byte, ALU low byte, ALU high byte.
- TX_BUSY high in IDLE with slots full: no transmit until it falls.
- CTRL_BUSY = (state != IDLE) OR either slot full, registered.
- Reset mid-transfer: immediate abort, slots cleared, no partial resend after reset.
- Illegal state encoding: go to IDLE with TX_D_VLD=0.

Decomposition:
- Shared package (sys_ctrl_pkg):
  - 3-bit state encoding constants for the seven states.
  - Command opcode constants (AA/BB/CC/DD), shared with the receive controller.
- Sub-module tx_result_slot, instantiated twice:
  - Parameterised width; ports for capture strobe, data, release, full, stored data, overrun pulse.
  - Holds the capture/release/overrun rules above.

Test Plan:
- RF_RdData=0x5A strobed, TX_BUSY model 10-cycle frames -> one byte 0x5A, TX_D_VLD first high 2 cycles after strobe, CTRL_BUSY falls after TX_BUSY falls.
- ALU_OUT=0x1234 strobed -> bytes 0x34 then 0x12, TX_D_VLD low during each TX_BUSY window.
- RF=0xA1 and ALU=0xBEEF strobed same cycle -> bytes 0xA1, 0xEF, 0xBE, no OVERRUN.
- Two RF strobes (0x01, 0x02) while first byte in flight, third strobe 0x03 while slot full -> 0x01, 0x02 sent; 0x03 dropped with a single OVERRUN pulse.
- TX_BUSY held high 20 cycles before RF strobe 0x77 -> TX_D_VLD stays 0 until TX_BUSY falls, then 0x77 sent.
- RST asserted during ALU_LO_WAIT after 0x34 accepted -> all outputs 0 asynchronously, 0x12 never sent, next RF strobe 0x99 sent normally.
